layer_argmax_classifier: RTL

- Final classification stage. Sits directly downstream of the last fully-connected layer of float32 neuron nodes.
- Captures the N_IN registered, ReLU-clipped IEEE-754 single-precision node outputs as one packed vector.
- Scans the vector one element per clock and reports the index and value of the largest element.
- The result is held under a valid/ready handshake for the host or ARM interface.

---
 rtl/layer_argmax_classifier.sv | 94 +++++++++
 1 files changed

// File: rtl/layer_argmax_classifier.sv
// layer_argmax_classifier: serial float32 argmax over a captured layer vector, one element per clock.
// The result is held in DONE under a valid/ready handshake.
module layer_argmax_classifier #(
    parameter int N_IN  = 8,
    parameter int IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*32-1:0]   in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     out_class,
    output logic [31:0]          out_max,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t              state;
    logic [N_IN*32-1:0]  vec;
    logic [31:0]         best, cur, nxt_best;
    logic [IDX_W-1:0]    best_idx, cnt, nxt_idx;
    logic                take, last;

    // Strict float greater-than; NaN never wins, and any non-NaN beats a NaN incumbent.
    function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan;
        a_nan = &a[30:23] && |a[22:0];
        b_nan = &b[30:23] && |b[22:0];
        return a_nan ? 1'b0 :
               b_nan ? 1'b1 :
               (a[30:0] == 31'd0 && b[30:0] == 31'd0) ? 1'b0 :
               (a[31] != b[31]) ? !a[31] :
               a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
    endfunction

    assign cur      = vec[32*int'(cnt) +: 32];
    assign last     = int'(cnt) == N_IN - 1;
    assign in_ready = state == IDLE && !rst;
    assign busy     = state != IDLE;

    always_comb begin
        take     = gt(cur, best);
        nxt_best = take ? cur : best;
        nxt_idx  = take ? cnt : best_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_class <= '0;
            out_max   <= '0;
            best      <= '0;
            best_idx  <= '0;
            cnt       <= '0;
            vec       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    vec      <= in_vec;
                    best     <= in_vec[31:0];
                    best_idx <= '0;
                    cnt      <= IDX_W'(1);
                    if (N_IN == 1) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_class <= '0;
                        out_max   <= in_vec[31:0];
                    end else begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    best     <= nxt_best;
                    best_idx <= nxt_idx;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_class <= nxt_idx;
                        out_max   <= nxt_best;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
